// File: rtl/convertidor_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   estado_t     : controller states (REPOSO, DESPLAZAR, FIN)
//   ANCHO_DIGITO : width of one BCD digit
//   potencia10() : 10^n, used for elaboration-time sizing checks
package convertidor_bcd_pkg;

  localparam int ANCHO_DIGITO = 4;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    DESPLAZAR = 2'd1,
    FIN       = 2'd2
  } estado_t;

  function automatic logic [63:0] potencia10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/convertidor_binario_bcd_secuencial_corrector.sv
// corrector_digito_bcd: combinational add-3 correction for one BCD digit.
// A digit of 5 or more is raised by 3 so that the following left shift
// carries correctly into the next decimal digit.
//   digito_i : current digit value (4 bits)
//   digito_o : corrected digit value (4 bits)
module corrector_digito_bcd
  import convertidor_bcd_pkg::*;
(
  input  logic [ANCHO_DIGITO-1:0] digito_i,
  output logic [ANCHO_DIGITO-1:0] digito_o
);

  assign digito_o = (digito_i >= ANCHO_DIGITO'(5)) ? digito_i + ANCHO_DIGITO'(3)
                                                   : digito_i;

endmodule

// File: rtl/convertidor_binario_bcd_secuencial.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
//
// Ports:
//   clk            : clock, all state updates on the rising edge
//   rst            : synchronous reset, active high
//   inicio         : conversion request, only looked at in REPOSO
//   entradaBinario : value to convert, captured on the accepting edge
//   salidaBCD      : registered result, digit 0 (units) in bits [3:0]
//   listo          : one-cycle pulse when salidaBCD has a new value
//   ocupado        : high while a conversion is in flight
//   salidaSigno    : (CONVERTIDOR_SIGNO_EN only) 1 = input was negative
//
// Build option CONVERTIDOR_SIGNO_EN: input is two's complement, the magnitude
// is converted and the sign is reported on salidaSigno.
//
// state     | meaning
// ----------+---------------------------------------------------------
// REPOSO    | idle, waiting for inicio
// DESPLAZAR | one add-3 + shift step per cycle, ANCHO cycles in total
// FIN       | result just loaded, listo pulse
module convertidor_binario_bcd_secuencial
  import convertidor_bcd_pkg::*;
#(
  parameter int ANCHO   = 8,
  parameter int DIGITOS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            inicio,
  input  logic [ANCHO-1:0]                entradaBinario,
  output logic [ANCHO_DIGITO*DIGITOS-1:0] salidaBCD,
  output logic                            listo,
  output logic                            ocupado
`ifdef CONVERTIDOR_SIGNO_EN
  ,
  output logic                            salidaSigno
`endif
);

  localparam int ANCHO_BCD = ANCHO_DIGITO * DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO + 1);

  if (ANCHO < 4 || ANCHO > 32) begin : g_chk_ancho
    $error("ANCHO must be within 4..32");
  end

  if (potencia10(DIGITOS) <= ((64'd1 << ANCHO) - 64'd1)) begin : g_chk_digitos
    $error("DIGITOS too small to hold 2^ANCHO-1");
  end

  estado_t                estado_q, estado_d;
  logic [ANCHO_CNT-1:0]   contador_q, contador_d;
  logic [ANCHO-1:0]       binario_q, binario_d;
  logic [ANCHO_BCD-1:0]   digitos_q, digitos_d;
  logic [ANCHO_BCD-1:0]   salida_bcd_q, salida_bcd_d;

  logic                   acepta;
  logic                   ultimo;
  logic [ANCHO-1:0]       magnitud;
  logic [ANCHO_BCD-1:0]   digitos_corr;
  logic [ANCHO_BCD+ANCHO-1:0] combinado;

  assign acepta = (estado_q == REPOSO) && inicio;
  assign ultimo = (estado_q == DESPLAZAR) && (contador_q == ANCHO_CNT'(1));

`ifdef CONVERTIDOR_SIGNO_EN
  logic negativo;
  logic signo_q, signo_d;
  logic salida_signo_q, salida_signo_d;

  // Negating -2^(ANCHO-1) wraps back to itself, which read as unsigned is
  // exactly the required magnitude.
  assign negativo = entradaBinario[ANCHO-1];
  assign magnitud = negativo ? (ANCHO'(0) - entradaBinario) : entradaBinario;
`else
  assign magnitud = entradaBinario;
`endif

  for (genvar g = 0; g < DIGITOS; g++) begin : g_corr
    corrector_digito_bcd u_corr (
      .digito_i (digitos_q[g*ANCHO_DIGITO +: ANCHO_DIGITO]),
      .digito_o (digitos_corr[g*ANCHO_DIGITO +: ANCHO_DIGITO])
    );
  end

  // Corrected digits and remaining binary bits shift as one register; the
  // bit leaving the top is always zero when DIGITOS is sized correctly.
  assign combinado = {digitos_corr, binario_q} << 1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      REPOSO:    if (inicio) estado_d = DESPLAZAR;
      DESPLAZAR: if (contador_q == ANCHO_CNT'(1)) estado_d = FIN;
      FIN:       estado_d = REPOSO;
      default:   estado_d = REPOSO;
    endcase
  end

  // Output decode
  always_comb begin
    listo   = 1'b0;
    ocupado = 1'b0;
    unique case (estado_q)
      REPOSO:    ;
      DESPLAZAR: ocupado = 1'b1;
      FIN: begin
        listo   = 1'b1;
        ocupado = 1'b1;
      end
      default:   ;
    endcase
  end

  // Datapath next values
  always_comb begin
    contador_d   = contador_q;
    binario_d    = binario_q;
    digitos_d    = digitos_q;
    salida_bcd_d = salida_bcd_q;
`ifdef CONVERTIDOR_SIGNO_EN
    signo_d        = signo_q;
    salida_signo_d = salida_signo_q;
`endif
    if (acepta) begin
      binario_d  = magnitud;
      digitos_d  = '0;
      contador_d = ANCHO_CNT'(ANCHO);
`ifdef CONVERTIDOR_SIGNO_EN
      signo_d    = negativo;
`endif
    end else if (estado_q == DESPLAZAR) begin
      digitos_d  = combinado[ANCHO_BCD+ANCHO-1:ANCHO];
      binario_d  = combinado[ANCHO-1:0];
      contador_d = contador_q - ANCHO_CNT'(1);
      if (ultimo) begin
        salida_bcd_d = combinado[ANCHO_BCD+ANCHO-1:ANCHO];
`ifdef CONVERTIDOR_SIGNO_EN
        salida_signo_d = signo_q;
`endif
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      contador_q   <= '0;
      binario_q    <= '0;
      digitos_q    <= '0;
      salida_bcd_q <= '0;
`ifdef CONVERTIDOR_SIGNO_EN
      signo_q        <= 1'b0;
      salida_signo_q <= 1'b0;
`endif
    end else begin
      contador_q   <= contador_d;
      binario_q    <= binario_d;
      digitos_q    <= digitos_d;
      salida_bcd_q <= salida_bcd_d;
`ifdef CONVERTIDOR_SIGNO_EN
      signo_q        <= signo_d;
      salida_signo_q <= salida_signo_d;
`endif
    end
  end

  assign salidaBCD = salida_bcd_q;
`ifdef CONVERTIDOR_SIGNO_EN
  assign salidaSigno = salida_signo_q;
`endif

endmodule

// File: tb/tb_convertidor_binario_bcd_secuencial.sv
module tb_convertidor_binario_bcd_secuencial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, inicio8;
  logic [7:0]  ent8;
  logic [11:0] bcd8;
  logic        listo8, ocup8, signo8;

  logic        rst4, inicio4;
  logic [3:0]  ent4;
  logic [7:0]  bcd4;
  logic        listo4, ocup4, signo4;

  convertidor_binario_bcd_secuencial #(.ANCHO(8), .DIGITOS(3)) dut8 (
    .clk            (clk),
    .rst            (rst8),
    .inicio         (inicio8),
    .entradaBinario (ent8),
    .salidaBCD      (bcd8),
    .listo          (listo8),
    .ocupado        (ocup8)
`ifdef CONVERTIDOR_SIGNO_EN
    ,
    .salidaSigno    (signo8)
`endif
  );

  convertidor_binario_bcd_secuencial #(.ANCHO(4), .DIGITOS(2)) dut4 (
    .clk            (clk),
    .rst            (rst4),
    .inicio         (inicio4),
    .entradaBinario (ent4),
    .salidaBCD      (bcd4),
    .listo          (listo4),
    .ocupado        (ocup4)
`ifdef CONVERTIDOR_SIGNO_EN
    ,
    .salidaSigno    (signo4)
`endif
  );

`ifdef CONVERTIDOR_SIGNO_EN
  localparam bit SIGNO = 1'b1;
`else
  localparam bit SIGNO = 1'b0;
  assign signo8 = 1'b0;
  assign signo4 = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nombre, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nombre, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits of the (possibly sign-corrected) value.
  typedef struct {
    logic [11:0] bcd;
    logic        s;
  } ref_t;

  function automatic ref_t modelo(input int unsigned v, input int ancho);
    ref_t r;
    int unsigned mag;
    mag   = v;
    r.s   = 1'b0;
    r.bcd = '0;
    if (SIGNO && v >= (32'd1 << (ancho - 1))) begin
      mag = (32'd1 << ancho) - v;
      r.s = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      r.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  // One full request on the selected instance; input is disturbed after acceptance.
  task automatic convertir(input bit sel, input int unsigned v,
                           output logic [11:0] bcd, output logic s,
                           output int lat, output int occ, output bit estable);
    logic [11:0] prev;
    bit visto;
    prev = sel ? {4'h0, bcd4} : bcd8;
    if (sel) begin ent4 = 4'(v); inicio4 = 1'b1; end
    else     begin ent8 = 8'(v); inicio8 = 1'b1; end
    tick;
    inicio8 = 1'b0;
    inicio4 = 1'b0;
    if (sel) ent4 = ~ent4; else ent8 = ~ent8;
    occ = (sel ? ocup4 : ocup8) ? 1 : 0;
    lat = 0; estable = 1'b1; visto = 1'b0; bcd = '0; s = 1'b0;
    while (!visto && lat < 20) begin
      tick;
      lat++;
      if (sel ? ocup4 : ocup8) occ++;
      if (sel ? listo4 : listo8) begin
        visto = 1'b1;
        bcd   = sel ? {4'h0, bcd4} : bcd8;
        s     = sel ? signo4 : signo8;
      end else if ((sel ? {4'h0, bcd4} : bcd8) != prev) begin
        estable = 1'b0;
      end
    end
    if (!visto) lat = -1;
    tick;
  endtask

  typedef struct {
    logic [7:0]  ent;
    logic [11:0] bcd;
    logic        s;
  } vec_t;

  vec_t tabla[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] got_bcd;
    logic        got_s;
    int          lat, occ, n_listo, k_listo;
    bit          est;
    ref_t        m;
    int unsigned v;

    tabla[0] = '{8'd0,   12'h000, 1'b0};
    tabla[1] = '{8'd1,   12'h001, 1'b0};
    tabla[2] = '{8'd9,   12'h009, 1'b0};
    tabla[3] = '{8'd10,  12'h010, 1'b0};
    tabla[4] = '{8'd37,  12'h037, 1'b0};
    tabla[5] = '{8'd99,  12'h099, 1'b0};
    tabla[6] = '{8'd100, 12'h100, 1'b0};
    tabla[7] = '{8'd127, 12'h127, 1'b0};
`ifdef CONVERTIDOR_SIGNO_EN
    tabla[8]  = '{8'h80, 12'h128, 1'b1};
    tabla[9]  = '{8'hFF, 12'h001, 1'b1};
    tabla[10] = '{8'hC8, 12'h056, 1'b1};
`else
    tabla[8]  = '{8'd128, 12'h128, 1'b0};
    tabla[9]  = '{8'd200, 12'h200, 1'b0};
    tabla[10] = '{8'd255, 12'h255, 1'b0};
`endif

    // Reset with inicio asserted: reset must win.
    rst8 = 1'b1; rst4 = 1'b1; inicio8 = 1'b1; inicio4 = 1'b1;
    ent8 = 8'd77; ent4 = 4'd7;
    tick; tick;
    chk("reset_bcd8", bcd8, 0);
    chk("reset_listo8", listo8, 0);
    chk("reset_ocupado8", ocup8, 0);
    chk("reset_signo8", signo8, 0);
    chk("reset_bcd4", bcd4, 0);
    chk("reset_ocupado4", ocup4, 0);
    rst8 = 1'b0; rst4 = 1'b0; inicio8 = 1'b0; inicio4 = 1'b0;
    tick;
    chk("idle_ocupado8", ocup8, 0);

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      convertir(1'b0, tabla[i].ent, got_bcd, got_s, lat, occ, est);
      chk($sformatf("tabla[%0d]_bcd", i), got_bcd, tabla[i].bcd);
      chk($sformatf("tabla[%0d]_signo", i), got_s, tabla[i].s);
      chk($sformatf("tabla[%0d]_latencia", i), lat, 8);
      chk($sformatf("tabla[%0d]_ocupado_ciclos", i), occ, 9);
      chk($sformatf("tabla[%0d]_estable", i), est, 1);
      chk($sformatf("tabla[%0d]_listo_pulso", i), listo8, 0);
      chk($sformatf("tabla[%0d]_ocupado_fin", i), ocup8, 0);
    end

    // Full-scale input.
    convertir(1'b0, 255, got_bcd, got_s, lat, occ, est);
    m = modelo(255, 8);
    chk("max_bcd", got_bcd, m.bcd);
    chk("max_latencia", lat, 8);
    chk("max_ocupado_ciclos", occ, 9);

    // Zero followed by 100: no stale digits.
    convertir(1'b0, 0, got_bcd, got_s, lat, occ, est);
    chk("cero_bcd", got_bcd, 12'h000);
    convertir(1'b0, 100, got_bcd, got_s, lat, occ, est);
    chk("cien_bcd", got_bcd, 12'h100);

    // Second request during conversion must be ignored.
    ent8 = 8'd37; inicio8 = 1'b1;
    tick;
    inicio8 = 1'b0;
    tick; tick;
    ent8 = 8'd99; inicio8 = 1'b1;
    tick;
    inicio8 = 1'b0;
    n_listo = 0; k_listo = -1; got_bcd = '0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (listo8) begin
        n_listo++;
        k_listo = k;
        got_bcd = bcd8;
      end
    end
    chk("ignora_inicio_pulsos", n_listo, 1);
    chk("ignora_inicio_bcd", got_bcd, 12'h037);
    chk("ignora_inicio_latencia", k_listo, 4);
    chk("ignora_inicio_retiene", bcd8, 12'h037);

    // Reset mid-conversion aborts with no listo.
    ent8 = 8'd200; inicio8 = 1'b1;
    tick;
    inicio8 = 1'b0;
    tick; tick; tick;
    rst8 = 1'b1;
    tick;
    chk("abort_bcd", bcd8, 0);
    chk("abort_listo", listo8, 0);
    chk("abort_ocupado", ocup8, 0);
    rst8 = 1'b0;
    n_listo = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (listo8) n_listo++;
    end
    chk("abort_sin_listo", n_listo, 0);
    convertir(1'b0, 42, got_bcd, got_s, lat, occ, est);
    chk("tras_abort_bcd", got_bcd, 12'h042);
    chk("tras_abort_latencia", lat, 8);

    // Random values against the reference model.
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 255);
      convertir(1'b0, v, got_bcd, got_s, lat, occ, est);
      m = modelo(v, 8);
      chk($sformatf("rand[%0d]_bcd_%0d", i, v), got_bcd, m.bcd);
      chk($sformatf("rand[%0d]_signo_%0d", i, v), got_s, m.s);
      chk($sformatf("rand[%0d]_latencia", i), lat, 8);
      chk($sformatf("rand[%0d]_estable", i), est, 1);
    end

    // Narrow instance, exhaustive.
    for (int i = 0; i < 16; i++) begin
      convertir(1'b1, i, got_bcd, got_s, lat, occ, est);
      m = modelo(i, 4);
      chk($sformatf("a4[%0d]_bcd", i), got_bcd, m.bcd);
      chk($sformatf("a4[%0d]_signo", i), got_s, m.s);
      chk($sformatf("a4[%0d]_latencia", i), lat, 4);
      chk($sformatf("a4[%0d]_ocupado_ciclos", i), occ, 5);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/convertidor_binario_bcd_secuencial.md
CONVERTIDOR_BINARIO_BCD_SECUENCIAL -- requirements
Module: convertidor_binario_bcd_secuencial

Interface
REQ-001 SHALL have parameter ANCHO, default 8, binary input width; legal range 4..32.
REQ-002 SHALL have parameter DIGITOS, default 3, number of BCD output digits; 10^DIGITOS SHALL exceed 2^ANCHO-1, checked by elaboration-time assertion.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port inicio  input  1  conversion request, sampled only in REPOSO.
REQ-006 SHALL have port entradaBinario  input  ANCHO  value to convert, captured on the edge that accepts inicio.
REQ-007 SHALL have port salidaBCD  output  4*DIGITOS  result, digit 0 (units) in bits [3:0], registered.
REQ-008 SHALL have port listo  output  1  one-cycle pulse marking a new salidaBCD.
REQ-009 SHALL have port ocupado  output  1  high while a conversion is in flight; inicio is ignored while high.

Function
REQ-010 SHALL implement shift-add-3 (double dabble), one bit per clock.
REQ-011 SHALL use FSM states REPOSO, DESPLAZAR, FIN: REPOSO->DESPLAZAR on inicio=1; DESPLAZAR->FIN after ANCHO shifts; FIN->REPOSO unconditionally.
REQ-012 SHALL, on acceptance edge: load a shift register with entradaBinario, clear BCD digits to 0, and load the shift counter with ANCHO.
REQ-013 SHALL, per DESPLAZAR cycle: add 3 to every digit >=5, then shift {digits, binary} left by 1 bit, decrement counter.
REQ-014 SHALL load salidaBCD on the edge performing the final shift; listo=1 and ocupado=1 exactly in FIN.
REQ-015 SHALL give latency of exactly ANCHO cycles from the inicio-sampling edge to listo high; throughput one conversion per ANCHO+2 cycles.
REQ-016 SHALL hold salidaBCD stable between listo pulses; it changes only on entry to FIN.
REQ-017 SHALL ignore inicio in DESPLAZAR and FIN, with no queuing; entradaBinario changes mid-conversion SHALL have no effect.
REQ-018 SHALL convert 0 to all-zero digits and 2^ANCHO-1 to its exact decimal value, with no overflow at the DIGITOS limit.
REQ-019 SHALL have no combinational path from any input to any output.

Reset
REQ-020 SHALL, with rst=1 at an edge: state=REPOSO, salidaBCD=0, listo=0, ocupado=0, counter=0, shift register=0.
REQ-021 SHALL let rst override inicio in the same cycle.
REQ-022 SHALL, on rst mid-conversion, abort the conversion with no listo pulse; salidaBCD reads 0.

Configuration
REQ-023 SHALL support macro CONVERTIDOR_SIGNO_EN.
REQ-024 SHALL, when CONVERTIDOR_SIGNO_EN is defined: treat entradaBinario as two's complement, convert its magnitude (-2^(ANCHO-1) gives 2^(ANCHO-1)), and add output port salidaSigno (1 bit, 1=negative, registered with salidaBCD, reset 0).
REQ-025 SHALL, when CONVERTIDOR_SIGNO_EN is undefined: treat input as unsigned, with no salidaSigno port.

Structure
REQ-026 SHALL place the FSM state enum (REPOSO, DESPLAZAR, FIN) and the BCD digit width constant (4) in package convertidor_bcd_pkg.
REQ-027 SHALL instantiate combinational sub-module corrector_digito_bcd (4-bit in/out, +3 when >=5) once per digit via generate.

Verification (ANCHO=8, DIGITOS=3 unless stated)
REQ-028 SHALL cover: entradaBinario=255, inicio pulse -> listo exactly 8 cycles later, salidaBCD=12'h255, ocupado high for 9 cycles.
REQ-029 SHALL cover: entradaBinario=0 -> salidaBCD=12'h000; then 100 -> 12'h100 on the next listo, with no stale digits.
REQ-030 SHALL cover: inicio with 37, then inicio with 99 at cycle 3 -> single listo, salidaBCD=12'h037.
REQ-031 SHALL cover: inicio with 200, rst at cycle 4 -> no listo, outputs 0; new inicio with 42 -> 12'h042.
REQ-032 SHALL cover: CONVERTIDOR_SIGNO_EN, entradaBinario=8'h80 -> salidaBCD=12'h128, salidaSigno=1; 8'hFF -> 12'h001, salidaSigno=1.
REQ-033 SHALL cover: ANCHO=4, DIGITOS=2, exhaustive 0..15 -> 8'h00..8'h15, latency 4 cycles each.
